// File: rtl/cfg_pkg.sv
// ============================================================================
// Module  : cfg_pkg
// Brief   : Shared state encoding and frame constants for the config sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TILE    = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_ADDR_LO = 3'd3,
        ST_COUNT   = 3'd4,
        ST_DATA    = 3'd5,
        ST_DONE    = 3'd6
    } cfg_state_t;

    localparam logic [7:0] CFG_END_MARKER = 8'hFF;

    // Byte positions inside a frame; payload starts at FRAME_HDR_LEN.
    localparam int FRAME_POS_TILE    = 0;
    localparam int FRAME_POS_ADDR_HI = 1;
    localparam int FRAME_POS_ADDR_LO = 2;
    localparam int FRAME_POS_COUNT   = 3;
    localparam int FRAME_HDR_LEN     = 4;

    function automatic logic cfg_state_busy(input cfg_state_t s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_stream_sequencer_if.sv
// ============================================================================
// Module  : cfg_stream_sequencer_if
// Brief   : Bitstream input handshake and tile write-strobe bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cfg_stream_sequencer_if #(
    parameter int N_TILES = 16,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8
);
    logic                start;
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic [N_TILES-1:0]  select_tile;
    logic [ADDR_W-1:0]   address_tile;
    logic [DATA_W-1:0]   data_tile;
    logic                cfg_busy;
    logic                cfg_done;
    logic                cfg_error;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, select_tile, address_tile, data_tile,
               cfg_busy, cfg_done, cfg_error
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, select_tile, address_tile, data_tile,
               cfg_busy, cfg_done, cfg_error
    );
endinterface

`default_nettype wire

// File: rtl/cfg_onehot_dec.sv
// ============================================================================
// Module  : cfg_onehot_dec
// Brief   : Tile id to one-hot select; all-zero with o_in_range low if id too big.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cfg_onehot_dec #(
    parameter int N_TILES = 16,
    parameter int ID_W    = 8
) (
    input  wire logic [ID_W-1:0]    i_tile_id,
    output logic      [N_TILES-1:0] o_onehot,
    output logic                    o_in_range
);

    for (genvar i = 0; i < N_TILES; i++) begin : g_bit
        assign o_onehot[i] = (i_tile_id == ID_W'(i));
    end

    assign o_in_range = |o_onehot;

endmodule

`default_nettype wire

// File: rtl/cfg_stream_sequencer.sv
// ============================================================================
// Module  : cfg_stream_sequencer
// Brief   : Parses a byte-wide config bitstream into one-cycle tile write strobes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cfg_stream_sequencer
    import cfg_pkg::*;
#(
    parameter int N_TILES = 16,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8
) (
    input  wire logic             conf,
    input  wire logic             reset,
    cfg_stream_sequencer_if.slave bus
);

    cfg_state_t         r_state;
    cfg_state_t         w_next_state;
    logic [N_TILES-1:0] r_tile_sel;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_cnt;
    logic               w_busy;
    logic               w_accept;
    logic               w_is_end;
    logic [N_TILES-1:0] w_dec_onehot;
    logic               w_dec_in_range;

    assign w_busy       = cfg_state_busy(r_state);
    assign bus.in_ready = w_busy;
    assign bus.cfg_busy = w_busy;
    assign w_accept     = bus.in_valid && w_busy;
    assign w_is_end     = (bus.in_data == CFG_END_MARKER);

    // Decoding the incoming byte lets the select be latched with the tile id.
    cfg_onehot_dec #(
        .N_TILES (N_TILES),
        .ID_W    (DATA_W)
    ) u_onehot_dec (
        .i_tile_id  (bus.in_data),
        .o_onehot   (w_dec_onehot),
        .o_in_range (w_dec_in_range)
    );

    always_ff @(posedge conf or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (bus.start) w_next_state = ST_TILE;
            ST_TILE:          if (w_accept)  w_next_state = w_is_end ? ST_DONE : ST_ADDR_HI;
            ST_ADDR_HI:       if (w_accept)  w_next_state = ST_ADDR_LO;
            ST_ADDR_LO:       if (w_accept)  w_next_state = ST_COUNT;
            ST_COUNT:         if (w_accept)  w_next_state = ST_DATA;
            ST_DATA:          if (w_accept && (r_cnt == '0)) w_next_state = ST_TILE;
            default:          w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge conf or negedge reset) begin
        if (!reset) begin
            r_tile_sel       <= '0;
            r_addr           <= '0;
            r_cnt            <= '0;
            bus.select_tile  <= '0;
            bus.address_tile <= '0;
            bus.data_tile    <= '0;
            bus.cfg_done     <= 1'b0;
            bus.cfg_error    <= 1'b0;
        end else begin
            bus.select_tile <= '0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        bus.cfg_done  <= 1'b0;
                        bus.cfg_error <= 1'b0;
                    end
                end
                ST_TILE: begin
                    if (w_accept) begin
                        if (w_is_end) begin
                            bus.cfg_done <= 1'b1;
                        end else begin
                            // Out-of-range ids latch an all-zero select; payload is still consumed.
                            r_tile_sel <= w_dec_onehot;
                            if (!w_dec_in_range) bus.cfg_error <= 1'b1;
                        end
                    end
                end
                ST_ADDR_HI: if (w_accept) r_addr <= {bus.in_data[ADDR_W-9:0], r_addr[7:0]};
                ST_ADDR_LO: if (w_accept) r_addr <= {r_addr[ADDR_W-1:8], bus.in_data};
                ST_COUNT:   if (w_accept) r_cnt  <= bus.in_data;
                ST_DATA: begin
                    if (w_accept) begin
                        bus.select_tile  <= r_tile_sel;
                        bus.address_tile <= r_addr;
                        bus.data_tile    <= bus.in_data;
                        r_addr           <= r_addr + ADDR_W'(1);
                        r_cnt            <= r_cnt - DATA_W'(1);
                        if (&r_addr) bus.cfg_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cfg_stream_sequencer.sv
// ============================================================================
// Module  : tb_cfg_stream_sequencer
// Brief   : Randomized bitstream bench against a frame-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cfg_stream_sequencer;
    import cfg_pkg::*;

    localparam int N_TILES = 16;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;

    logic conf    = 1'b0;
    logic reset_n = 1'b0;

    cfg_stream_sequencer_if #(.N_TILES(N_TILES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cfg_stream_sequencer #(
        .N_TILES (N_TILES),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .conf  (conf),
        .reset (reset_n),
        .bus   (bus)
    );

    always #5 conf = ~conf;

    int n_checks = 0;
    int n_errors = 0;

    logic [N_TILES-1:0] obs_sel[$];
    logic [ADDR_W-1:0]  obs_addr[$];
    logic [7:0]         obs_data[$];
    logic [N_TILES-1:0] exp_sel[$];
    logic [ADDR_W-1:0]  exp_addr[$];
    logic [7:0]         exp_data[$];
    logic               exp_done;
    logic               exp_err;
    logic [7:0]         stim[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge conf) begin
        #1;
        if (bus.select_tile !== '0) begin
            check_eq("strobe_onehot", $countones(bus.select_tile), 1);
            obs_sel.push_back(bus.select_tile);
            obs_addr.push_back(bus.address_tile);
            obs_data.push_back(bus.data_tile);
        end
    end

    task automatic push_exp(input int unsigned t, input int unsigned a, input logic [7:0] d);
        logic [N_TILES-1:0] one;
        one = 1;
        exp_sel.push_back(one << t);
        exp_addr.push_back(ADDR_W'(a));
        exp_data.push_back(d);
    endtask

    // Frame-level model: walks the byte list and lists the writes it implies.
    task automatic model_stream(input logic [7:0] s[$]);
        int          i;
        int unsigned t, a, n;
        i = 0;
        while (i < s.size()) begin
            t = s[i + FRAME_POS_TILE];
            if (t == CFG_END_MARKER) begin
                exp_done = 1'b1;
                break;
            end
            a = (s[i + FRAME_POS_ADDR_HI] % (1 << (ADDR_W - 8))) * 256 + s[i + FRAME_POS_ADDR_LO];
            n = s[i + FRAME_POS_COUNT] + 1;
            if (t >= N_TILES) exp_err = 1'b1;
            for (int k = 0; k < n; k++) begin
                if (t < N_TILES) push_exp(t, a, s[i + FRAME_HDR_LEN + k]);
                if (a == (1 << ADDR_W) - 1) exp_err = 1'b1;
                a = (a + 1) % (1 << ADDR_W);
            end
            i += FRAME_HDR_LEN + n;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit sent;
        sent = 1'b0;
        for (int cyc = 0; cyc < 200 && !sent; cyc++) begin
            @(negedge conf);
            bus.in_data  = b;
            bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.in_valid && bus.in_ready) sent = 1'b1;
        end
        if (!sent) check_eq("send_timeout", 0, 1);
    endtask

    task automatic send_bytes(input logic [7:0] s[$], input bit gaps);
        foreach (s[i]) send_byte(s[i], gaps);
        @(negedge conf);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge conf);
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        @(negedge conf);
        bus.start    = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check_eq({tag, "_count"}, obs_sel.size(), exp_sel.size());
        n = (obs_sel.size() < exp_sel.size()) ? obs_sel.size() : exp_sel.size();
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_sel"},  obs_sel[i],  exp_sel[i]);
            check_eq({tag, "_addr"}, obs_addr[i], exp_addr[i]);
            check_eq({tag, "_data"}, obs_data[i], exp_data[i]);
        end
        obs_sel.delete();  obs_addr.delete();  obs_data.delete();
        exp_sel.delete();  exp_addr.delete();  exp_data.delete();
    endtask

    task automatic finish_stream(input string tag);
        repeat (3) @(posedge conf);
        #2;
        compare_writes(tag);
        check_eq({tag, "_done"},  bus.cfg_done,  exp_done);
        check_eq({tag, "_error"}, bus.cfg_error, exp_err);
        check_eq({tag, "_ready"}, bus.in_ready,  0);
        check_eq({tag, "_busy"},  bus.cfg_busy,  0);
    endtask

    task automatic fresh_start();
        pulse_start();
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int unsigned tile, hi, lo, cnt, nfr;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        exp_done     = 1'b0;
        exp_err      = 1'b0;

        repeat (3) @(posedge conf);
        #1;
        check_eq("rst_ready",  bus.in_ready,     0);
        check_eq("rst_select", bus.select_tile,  0);
        check_eq("rst_addr",   bus.address_tile, 0);
        check_eq("rst_data",   bus.data_tile,    0);
        check_eq("rst_busy",   bus.cfg_busy,     0);
        check_eq("rst_done",   bus.cfg_done,     0);
        check_eq("rst_error",  bus.cfg_error,    0);
        @(negedge conf);
        reset_n = 1'b1;

        // Basic frame then end marker
        fresh_start();
        check_eq("t1_busy", bus.cfg_busy, 1);
        stim = {8'h03, 8'h00, 8'h10, 8'h01, 8'hAA, 8'hBB, 8'hFF};
        model_stream(stim);
        send_bytes(stim, 1'b0);
        finish_stream("t1");

        // Start from DONE clears done and re-arms the parser
        fresh_start();
        check_eq("done_cleared", bus.cfg_done, 0);
        check_eq("rearm_ready",  bus.in_ready, 1);
        stim = {8'h02, 8'h03, 8'hFE, 8'h02, 8'h11, 8'h22, 8'h33, 8'hFF};
        model_stream(stim);
        send_bytes(stim, 1'b0);
        finish_stream("t2_wrap");

        // Out-of-range tile followed by a good frame
        fresh_start();
        check_eq("error_cleared", bus.cfg_error, 0);
        stim = {8'h20, 8'h00, 8'h05, 8'h00, 8'h77,
                8'h04, 8'h01, 8'h23, 8'h00, 8'h5A, 8'hFF};
        model_stream(stim);
        send_bytes(stim, 1'b0);
        finish_stream("t3_badtile");

        // Random streams with valid gaps
        for (int it = 0; it < 8; it++) begin
            fresh_start();
            stim.delete();
            nfr = $urandom_range(1, 3);
            for (int f = 0; f < nfr; f++) begin
                tile = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 254) : $urandom_range(0, 15);
                hi   = $urandom_range(0, 255);
                lo   = $urandom_range(0, 255);
                if ($urandom_range(0, 3) == 0) begin
                    hi = hi | 3;
                    lo = $urandom_range(252, 255);
                end
                cnt  = (it == 0 && f == 0) ? 3 : $urandom_range(0, 5);
                stim.push_back(8'(tile));
                stim.push_back(8'(hi));
                stim.push_back(8'(lo));
                stim.push_back(8'(cnt));
                for (int k = 0; k <= cnt; k++) stim.push_back(8'($urandom_range(0, 255)));
            end
            stim.push_back(8'hFF);
            model_stream(stim);
            send_bytes(stim, 1'b1);
            finish_stream("rand");
        end

        // Start pulsed mid-payload must be ignored
        fresh_start();
        stim = {8'h30, 8'h00, 8'h00, 8'h00, 8'h99,
                8'h07, 8'h00, 8'h40, 8'h02, 8'h10, 8'h20, 8'h30, 8'hFF};
        model_stream(stim);
        for (int i = 0; i < 10; i++) send_byte(stim[i], 1'b0);
        pulse_start();
        check_eq("start_busy_ignored", bus.cfg_busy, 1);
        check_eq("start_busy_error",   bus.cfg_error, 1);
        for (int i = 10; i < stim.size(); i++) send_byte(stim[i], 1'b0);
        @(negedge conf);
        bus.in_valid = 1'b0;
        finish_stream("t6_start_in_data");

        // Reset during payload with three bytes outstanding
        fresh_start();
        stim = {8'h05, 8'h01, 8'h00, 8'h03, 8'hC1};
        push_exp(5, 'h100, 8'hC1);
        send_bytes(stim, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC2;
        reset_n      = 1'b0;
        #1;
        check_eq("mid_rst_select", bus.select_tile,  0);
        check_eq("mid_rst_addr",   bus.address_tile, 0);
        check_eq("mid_rst_data",   bus.data_tile,    0);
        check_eq("mid_rst_ready",  bus.in_ready,     0);
        check_eq("mid_rst_busy",   bus.cfg_busy,     0);
        @(negedge conf);
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
        compare_writes("t5_pre_reset");
        fresh_start();
        stim = {8'h09, 8'h00, 8'h07, 8'h01, 8'hE1, 8'hE2, 8'hFF};
        model_stream(stim);
        send_bytes(stim, 1'b0);
        finish_stream("t5_after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
